// File: rtl/pipe_control_if.sv
// pipe_control_if: IF/ID inputs and staged control outputs of the pipeline controller
interface pipe_control_if #(parameter int RD_W = 5);
  logic            id_valid_i;
  logic [31:0]     id_inst_i;
  logic            ex_flush_i;
  logic            stall_ext_i;
  logic            stall_ifid_o;
  logic            flush_ifid_o;
  logic            ex_valid_o;
  logic [6:0]      ex_alu_op_o;
  logic            ex_alu_src1_o;
  logic [1:0]      ex_alu_src2_o;
  logic [2:0]      ex_concat_o;
  logic            ex_branch_o;
  logic            ex_jump_o;
  logic            ex_jalr_o;
  logic [RD_W-1:0] ex_rd_o;
  logic            ex_illegal_o;
  logic            mem_valid_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic [3:0]      mem_be_o;
  logic [RD_W-1:0] mem_rd_o;
  logic            wb_valid_o;
  logic            wb_reg_write_o;
  logic            wb_memtoreg_o;
  logic [RD_W-1:0] wb_rd_o;
  modport master (
    output id_valid_i, id_inst_i, ex_flush_i, stall_ext_i,
    input  stall_ifid_o, flush_ifid_o,
    input  ex_valid_o, ex_alu_op_o, ex_alu_src1_o, ex_alu_src2_o, ex_concat_o,
    input  ex_branch_o, ex_jump_o, ex_jalr_o, ex_rd_o, ex_illegal_o,
    input  mem_valid_o, mem_read_o, mem_write_o, mem_be_o, mem_rd_o,
    input  wb_valid_o, wb_reg_write_o, wb_memtoreg_o, wb_rd_o
  );
  modport slave (
    input  id_valid_i, id_inst_i, ex_flush_i, stall_ext_i,
    output stall_ifid_o, flush_ifid_o,
    output ex_valid_o, ex_alu_op_o, ex_alu_src1_o, ex_alu_src2_o, ex_concat_o,
    output ex_branch_o, ex_jump_o, ex_jalr_o, ex_rd_o, ex_illegal_o,
    output mem_valid_o, mem_read_o, mem_write_o, mem_be_o, mem_rd_o,
    output wb_valid_o, wb_reg_write_o, wb_memtoreg_o, wb_rd_o
  );
endinterface

// File: rtl/pipe_control.sv
// pipe_control: RV32I ID decode plus ID/EX, EX/MEM, MEM/WB control registers with hazard/flush/freeze
module pipe_control #(
  parameter bit ENABLE_MEXT = 1'b0,
  parameter int RD_W        = 5
) (
  input logic           CLK,
  input logic           RSTn,
  pipe_control_if.slave bus
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  typedef struct packed {
    logic            valid;
    logic [6:0]      alu_op;
    logic            src1;
    logic [1:0]      src2;
    logic [2:0]      concat;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            illegal;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            memtoreg;
    logic [3:0]      be;
    logic [RD_W-1:0] rd;
  } ex_t;
  typedef struct packed {
    logic            valid;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            memtoreg;
    logic [3:0]      be;
    logic [RD_W-1:0] rd;
  } mem_t;
  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            memtoreg;
    logic [RD_W-1:0] rd;
  } wb_t;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [RD_W-1:0] id_rd;
  logic [RD_W-1:0] rs1;
  logic [RD_W-1:0] rs2;
  logic [3:0]      be_f3;
  logic            legal;
  logic            use_rs1;
  logic            use_rs2;
  logic            hz;
  ex_t             dec;
  ex_t             ex_d, ex_q;
  mem_t            mem_d, mem_q;
  wb_t             wb_d, wb_q;
  assign opc   = bus.id_inst_i[6:0];
  assign f3    = bus.id_inst_i[14:12];
  assign f7    = bus.id_inst_i[31:25];
  assign id_rd = RD_W'(bus.id_inst_i[11:7]);
  assign rs1   = RD_W'(bus.id_inst_i[19:15]);
  assign rs2   = RD_W'(bus.id_inst_i[24:20]);
  // Access width for loads/stores: byte, half or word from the low funct3 bits
  always_comb begin
    be_f3 = f3[1:0] == 2'b00 ? 4'b0001 :
            f3[1:0] == 2'b01 ? 4'b0011 :
            f3[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
  end
  // Decode the IF/ID instruction; illegal encodings collapse to a valid all-zero marker
  always_comb begin
    dec        = '0;
    legal      = 1'b1;
    dec.alu_op = opc;
    case (opc)
      OP_LUI: begin
        dec.src2      = 2'b01;
        dec.concat    = 3'b001;
        dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        dec.src1      = 1'b1;
        dec.src2      = 2'b01;
        dec.concat    = 3'b001;
        dec.reg_write = 1'b1;
      end
      OP_OP: begin
        dec.reg_write = 1'b1;
        legal         = f7 == 7'b0000000 || f7 == 7'b0100000 || (ENABLE_MEXT && f7 == 7'b0000001);
      end
      OP_IMM: begin
        dec.src2      = 2'b01;
        dec.concat    = (f3 == 3'b001 || f3 == 3'b101) ? 3'b110 : 3'b011;
        dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        dec.src2      = 2'b01;
        dec.concat    = 3'b011;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.memtoreg  = 1'b1;
        dec.be        = be_f3;
        legal         = !(f3 inside {3'b011, 3'b110, 3'b111});
      end
      OP_STORE: begin
        dec.src2      = 2'b01;
        dec.concat    = 3'b101;
        dec.mem_write = 1'b1;
        dec.be        = be_f3;
        legal         = f3 <= 3'b010;
      end
      OP_BRANCH: begin
        dec.concat = 3'b100;
        dec.branch = 1'b1;
      end
      OP_JAL: begin
        dec.src1      = 1'b1;
        dec.src2      = 2'b10;
        dec.concat    = 3'b010;
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
      end
      OP_JALR: begin
        dec.src2      = 2'b10;
        dec.concat    = 3'b011;
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.jalr      = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    dec.rd = dec.reg_write ? id_rd : '0;
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.valid = 1'b1;
  end
  // Load-use detection against the instruction currently in EX
  always_comb begin
    use_rs1 = !(opc inside {OP_LUI, OP_AUIPC, OP_JAL});
    use_rs2 = opc inside {OP_OP, OP_STORE, OP_BRANCH};
    hz      = bus.id_valid_i && ex_q.valid && ex_q.mem_read && (|ex_q.rd) &&
              ((use_rs1 && rs1 == ex_q.rd) || (use_rs2 && rs2 == ex_q.rd));
  end
  // Next stage contents: flush or load-use inserts a bubble into EX, downstream just shifts
  always_comb begin
    ex_d  = (!bus.id_valid_i || bus.ex_flush_i || hz) ? '0 : dec;
    mem_d = '{valid: ex_q.valid, mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
              reg_write: ex_q.reg_write, memtoreg: ex_q.memtoreg, be: ex_q.be, rd: ex_q.rd};
    wb_d  = '{valid: mem_q.valid, reg_write: mem_q.reg_write, memtoreg: mem_q.memtoreg, rd: mem_q.rd};
  end
  // Stage registers: reset beats everything, an external stall freezes all stages
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!bus.stall_ext_i) begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end
  assign bus.stall_ifid_o   = bus.stall_ext_i || (hz && !bus.ex_flush_i);
  assign bus.flush_ifid_o   = bus.ex_flush_i && !bus.stall_ext_i;
  assign bus.ex_valid_o     = ex_q.valid;
  assign bus.ex_alu_op_o    = ex_q.alu_op;
  assign bus.ex_alu_src1_o  = ex_q.src1;
  assign bus.ex_alu_src2_o  = ex_q.src2;
  assign bus.ex_concat_o    = ex_q.concat;
  assign bus.ex_branch_o    = ex_q.branch;
  assign bus.ex_jump_o      = ex_q.jump;
  assign bus.ex_jalr_o      = ex_q.jalr;
  assign bus.ex_rd_o        = ex_q.rd;
  assign bus.ex_illegal_o   = ex_q.illegal;
  assign bus.mem_valid_o    = mem_q.valid;
  assign bus.mem_read_o     = mem_q.mem_read;
  assign bus.mem_write_o    = mem_q.mem_write;
  assign bus.mem_be_o       = mem_q.be;
  assign bus.mem_rd_o       = mem_q.rd;
  assign bus.wb_valid_o     = wb_q.valid;
  assign bus.wb_reg_write_o = wb_q.reg_write;
  assign bus.wb_memtoreg_o  = wb_q.memtoreg;
  assign bus.wb_rd_o        = wb_q.rd;
endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: scoreboard bench for pipe_control, both ENABLE_MEXT settings in lockstep
module tb_pipe_control;
  typedef struct packed {
    logic v; logic [6:0] op; logic s1; logic [1:0] s2; logic [2:0] cc;
    logic br, jp, jr, il, mr, mw, rw, m2r; logic [3:0] be; logic [4:0] rd;
  } ctl_t;
  typedef struct packed { ctl_t e0, m0, w0, e1, m1, w1; } rec_t;
  logic CLK = 1'b0;
  logic RSTn;
  int   n_cmp = 0;
  int   n_err = 0;
  ctl_t me [2];
  ctl_t mm [2];
  ctl_t mw [2];
  rec_t rq [$];
  logic [3:0] cq [$];
  rec_t r;
  logic [3:0] c;
  pipe_control_if #(.RD_W(5)) b0 ();
  pipe_control_if #(.RD_W(5)) b1 ();
  pipe_control #(.ENABLE_MEXT(1'b0), .RD_W(5)) u0 (.CLK(CLK), .RSTn(RSTn), .bus(b0));
  pipe_control #(.ENABLE_MEXT(1'b1), .RD_W(5)) u1 (.CLK(CLK), .RSTn(RSTn), .bus(b1));
  always #5 CLK = ~CLK;
  function automatic ctl_t dec(logic [31:0] i, bit mext);
    ctl_t d = '0;
    bit ok = 1'b1;
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    d.op = i[6:0];
    case (i[6:0])
      7'h37: {d.s1, d.s2, d.cc, d.rw} = {1'b0, 2'b01, 3'b001, 1'b1};
      7'h17: {d.s1, d.s2, d.cc, d.rw} = {1'b1, 2'b01, 3'b001, 1'b1};
      7'h33: begin
        {d.s1, d.s2, d.cc, d.rw} = {1'b0, 2'b00, 3'b000, 1'b1};
        ok = (f7 == 7'h00) || (f7 == 7'h20) || (mext && f7 == 7'h01);
      end
      7'h13: {d.s1, d.s2, d.cc, d.rw} = {1'b0, 2'b01, (f3 == 3'd1 || f3 == 3'd5) ? 3'b110 : 3'b011, 1'b1};
      7'h03: begin
        {d.s1, d.s2, d.cc, d.rw, d.mr, d.m2r} = {1'b0, 2'b01, 3'b011, 1'b1, 1'b1, 1'b1};
        case (f3)
          3'd0, 3'd4: d.be = 4'b0001;
          3'd1, 3'd5: d.be = 4'b0011;
          3'd2:       d.be = 4'b1111;
          default:    ok = 1'b0;
        endcase
      end
      7'h23: begin
        {d.s1, d.s2, d.cc, d.mw} = {1'b0, 2'b01, 3'b101, 1'b1};
        case (f3)
          3'd0:    d.be = 4'b0001;
          3'd1:    d.be = 4'b0011;
          3'd2:    d.be = 4'b1111;
          default: ok = 1'b0;
        endcase
      end
      7'h63: {d.cc, d.br} = {3'b100, 1'b1};
      7'h6F: {d.s1, d.s2, d.cc, d.rw, d.jp} = {1'b1, 2'b10, 3'b010, 1'b1, 1'b1};
      7'h67: {d.s2, d.cc, d.rw, d.jp, d.jr} = {2'b10, 3'b011, 1'b1, 1'b1, 1'b1};
      default: ok = 1'b0;
    endcase
    if (d.rw) d.rd = i[11:7];
    if (!ok) begin
      d = '0;
      d.il = 1'b1;
    end
    d.v = 1'b1;
    return d;
  endfunction
  function automatic bit reads_rs1(logic [6:0] o);
    return !(o == 7'h37 || o == 7'h17 || o == 7'h6F);
  endfunction
  function automatic bit reads_rs2(logic [6:0] o);
    return o == 7'h33 || o == 7'h23 || o == 7'h63;
  endfunction
  function automatic logic [31:0] exv(ctl_t x);
    return 32'({x.v, x.op, x.s1, x.s2, x.cc, x.br, x.jp, x.jr, x.il, x.rd});
  endfunction
  function automatic logic [31:0] memv(ctl_t x);
    return 32'({x.v, x.mr, x.mw, x.be, x.rd});
  endfunction
  function automatic logic [31:0] wbv(ctl_t x);
    return 32'({x.v, x.rw, x.m2r, x.rd});
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(bit rstn, bit v, logic [31:0] inst, bit flush, bit stall);
    rec_t x;
    logic [3:0] cm;
    @(negedge CLK);
    RSTn = rstn;
    b0.id_valid_i = v; b0.id_inst_i = inst; b0.ex_flush_i = flush; b0.stall_ext_i = stall;
    b1.id_valid_i = v; b1.id_inst_i = inst; b1.ex_flush_i = flush; b1.stall_ext_i = stall;
    for (int k = 0; k < 2; k++) begin
      bit hz = v && me[k].v && me[k].mr && me[k].rd != 0 &&
               ((reads_rs1(inst[6:0]) && inst[19:15] == me[k].rd) ||
                (reads_rs2(inst[6:0]) && inst[24:20] == me[k].rd));
      cm[3-2*k] = stall || (hz && !flush);
      cm[2-2*k] = flush && !stall;
      if (!rstn) begin
        me[k] = '0; mm[k] = '0; mw[k] = '0;
      end else if (!stall) begin
        mw[k] = mm[k];
        mm[k] = me[k];
        me[k] = (v && !flush && !hz) ? dec(inst, k == 1) : '0;
      end
    end
    x = '{e0: me[0], m0: mm[0], w0: mw[0], e1: me[1], m1: mm[1], w1: mw[1]};
    rq.push_back(x);
    cq.push_back(cm);
  endtask
  function automatic logic [31:0] rnd_inst();
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
    int idx = $urandom_range(0, 10);
    logic [6:0] o = idx < 10 ? ops[idx] : 7'($urandom);
    logic [6:0] f7;
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(0, 3)), o};
  endfunction
  // Monitor for the combinational IF/ID controls, mid-cycle after stimulus settles
  initial forever begin
    @(negedge CLK);
    #2;
    if (cq.size() > 0) begin
      c = cq.pop_front();
      chk("stall_ifid0", 32'(b0.stall_ifid_o), 32'(c[3]));
      chk("flush_ifid0", 32'(b0.flush_ifid_o), 32'(c[2]));
      chk("stall_ifid1", 32'(b1.stall_ifid_o), 32'(c[1]));
      chk("flush_ifid1", 32'(b1.flush_ifid_o), 32'(c[0]));
    end
  end
  // Monitor for the stage registers, shortly after the edge that loaded them
  initial forever begin
    @(posedge CLK);
    #2;
    if (rq.size() > 0) begin
      r = rq.pop_front();
      chk("ex0", 32'({b0.ex_valid_o, b0.ex_alu_op_o, b0.ex_alu_src1_o, b0.ex_alu_src2_o, b0.ex_concat_o,
                      b0.ex_branch_o, b0.ex_jump_o, b0.ex_jalr_o, b0.ex_illegal_o, b0.ex_rd_o}), exv(r.e0));
      chk("mem0", 32'({b0.mem_valid_o, b0.mem_read_o, b0.mem_write_o, b0.mem_be_o, b0.mem_rd_o}), memv(r.m0));
      chk("wb0", 32'({b0.wb_valid_o, b0.wb_reg_write_o, b0.wb_memtoreg_o, b0.wb_rd_o}), wbv(r.w0));
      chk("ex1", 32'({b1.ex_valid_o, b1.ex_alu_op_o, b1.ex_alu_src1_o, b1.ex_alu_src2_o, b1.ex_concat_o,
                      b1.ex_branch_o, b1.ex_jump_o, b1.ex_jalr_o, b1.ex_illegal_o, b1.ex_rd_o}), exv(r.e1));
      chk("mem1", 32'({b1.mem_valid_o, b1.mem_read_o, b1.mem_write_o, b1.mem_be_o, b1.mem_rd_o}), memv(r.m1));
      chk("wb1", 32'({b1.wb_valid_o, b1.wb_reg_write_o, b1.wb_memtoreg_o, b1.wb_rd_o}), wbv(r.w1));
    end
  end
  // Directed scenarios followed by randomized traffic
  initial begin
    bit st = 1'b0;
    for (int k = 0; k < 2; k++) begin
      me[k] = '0; mm[k] = '0; mw[k] = '0;
    end
    cyc(0, 1, 32'h00500093, 1, 1);
    cyc(0, 0, 32'h0, 0, 0);
    cyc(1, 1, 32'h00500093, 0, 0);
    repeat (3) cyc(1, 0, 32'h0, 0, 0);
    cyc(1, 1, 32'h0000A103, 0, 0);
    cyc(1, 1, 32'h002101B3, 0, 0);
    cyc(1, 1, 32'h002101B3, 0, 0);
    cyc(1, 1, 32'h0000A003, 0, 0);
    cyc(1, 1, 32'h000001B3, 0, 0);
    repeat (3) cyc(1, 0, 32'h0, 0, 0);
    cyc(1, 1, 32'h00000063, 0, 0);
    cyc(1, 1, 32'h00102023, 1, 0);
    repeat (3) cyc(1, 0, 32'h0, 0, 0);
    cyc(1, 1, 32'h00500093, 0, 0);
    cyc(1, 1, 32'h0000A103, 0, 0);
    repeat (3) cyc(1, 1, 32'h002101B3, 0, 1);
    cyc(1, 1, 32'h002101B3, 0, 0);
    cyc(1, 1, 32'h002101B3, 0, 0);
    cyc(1, 1, 32'h00100023, 0, 0);
    cyc(1, 1, 32'h00101023, 0, 0);
    cyc(1, 1, 32'h00005203, 0, 0);
    cyc(1, 1, 32'h00002283, 0, 0);
    cyc(1, 1, 32'h00007303, 0, 0);
    cyc(1, 1, 32'h02208033, 0, 0);
    repeat (4) cyc(1, 0, 32'h0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      st = st ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 7) != 0, rnd_inst(),
          $urandom_range(0, 9) == 0, st);
    end
    cyc(1, 0, 32'h0, 0, 0);
    @(posedge CLK);
    #4;
    if (rq.size() != 0 || cq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d/%0d records left, expected 0", rq.size(), cq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
